lpddr3_dq_rx_align: RTL

Receive-side read-training and word-alignment block for one LPDDR3 DQ lane. It consumes the 8-bit deserialised read word from the lane IOD on every fabric clock. It sweeps the IOD input delay line through the MOVE/DIRECTION/LOAD controls to find and centre the passing window of a known training pattern, then resolves the 8-bit word rotation. After training it outputs aligned read data. It is the read-path counterpart of the per-lane TX/DM IOD wrappers and sits between the DQ IOD `RX_DATA` bus and the DDR controller read FIFO.

---
 rtl/lpddr3_rx_align_pkg.sv | 26 ++
 rtl/lpddr3_rx_word_rotator.sv | 42 ++++
 rtl/lpddr3_dq_rx_align.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lpddr3_rx_align_pkg.sv
// Shared types and helpers for the LPDDR3 DQ receive-side read-training block.
package lpddr3_rx_align_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_STEP,
    ST_CENTER,
    ST_FSETTLE,
    ST_FCHECK,
    ST_DONE,
    ST_FAIL
  } state_t;

  // Default training word; all eight rotations are distinct, so the
  // rotation that matches it is unambiguous.
  localparam logic [7:0] DEFAULT_PATTERN = 8'h1D;

  // Width of the delay-line tap counter.
  function automatic int tap_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/lpddr3_rx_word_rotator.sv
// Word rotator: keeps the previous deserialised word, selects the 8-bit
// window W_sel out of {current, previous}, and finds the lowest rotation
// whose window equals the training pattern.
module lpddr3_rx_word_rotator
  import lpddr3_rx_align_pkg::*;
#(
  parameter logic [7:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic [2:0] sel,
  output logic [7:0] word_sel,
  output logic       match,
  output logic [2:0] match_k
);

  logic [7:0]  prev;
  logic [15:0] stream;

  // Previous word register; bit 0 of prev is the earliest bit in the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= data_in;
  end

  assign stream   = {data_in, prev};
  assign word_sel = stream[sel +: 8];

  // Lowest-k match search: scanning downwards lets the smallest k win.
  always_comb begin
    match   = 1'b0;
    match_k = '0;
    for (int k = 7; k >= 0; k--) begin
      if (stream[k +: 8] == PATTERN) begin
        match   = 1'b1;
        match_k = 3'(k);
      end
    end
  end

endmodule

// File: rtl/lpddr3_dq_rx_align.sv
// LPDDR3 DQ lane read training and word alignment.
// Sweeps the IOD delay line to find the passing window of the training
// pattern, centres the delay in it, resolves the word rotation, then
// presents aligned read data.
// Optional build macro LPDDR3_RX_ALIGN_ERRCNT_EN adds MON_EN / ERR_CNT, a
// saturating count of aligned words that differ from the pattern in DONE.
module lpddr3_dq_rx_align
  import lpddr3_rx_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = DEFAULT_PATTERN,
  parameter int         DELAY_TAPS    = 128,
  parameter int         SETTLE_CYCLES = 8,
  parameter int         MATCH_CYCLES  = 16
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       TRAIN_START,
  input  logic [7:0] RX_DATA,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic [7:0] RX_DATA_OUT,
  output logic       RX_VALID,
  output logic       TRAIN_DONE,
  output logic       TRAIN_FAIL,
  output logic [7:0] WIN_START,
  output logic [7:0] WIN_END,
  output logic [7:0] TAP_CENTER,
  output logic [2:0] SLIP
`ifdef LPDDR3_RX_ALIGN_ERRCNT_EN
  ,
  input  logic        MON_EN,
  output logic [15:0] ERR_CNT
`endif
);

  localparam int TAP_W   = tap_width(DELAY_TAPS);
  localparam int CNT_MAX = (SETTLE_CYCLES > MATCH_CYCLES) ? SETTLE_CYCLES : MATCH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [TAP_W-1:0] tap;
  logic             edge0, oor_seen, chk_ok, phase;
  logic [2:0]       chk_k, slip;
  logic [7:0]       win_start, win_end, tap_center, data_out_p1;

  logic [7:0]       word_sel;
  logic             match;
  logic [2:0]       match_k;
  logic             first, k_ok, last_chk, last_set, oor_now, tap_max, at_center, start_ok;
  logic [8:0]       win_sum;
  logic [7:0]       center_calc, tap8;

  lpddr3_rx_word_rotator #(.PATTERN(TRAIN_PATTERN)) u_rot (
    .clk     (FAB_CLK),
    .rst_n   (ARST_N),
    .data_in (RX_DATA),
    .sel     (slip),
    .word_sel(word_sel),
    .match   (match),
    .match_k (match_k)
  );

  assign first       = (cnt == '0);
  assign k_ok        = first ? match : (chk_ok && match && (match_k == chk_k));
  assign last_chk    = (cnt == CNT_W'(MATCH_CYCLES - 1));
  assign last_set    = (cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign oor_now     = oor_seen | DELAY_LINE_OUT_OF_RANGE;
  assign tap_max     = (tap == TAP_W'(DELAY_TAPS - 1));
  assign win_sum     = {1'b0, win_start} + {1'b0, win_end};
  assign center_calc = win_sum[8:1];
  assign at_center   = (tap == center_calc[TAP_W-1:0]);
  assign tap8        = 8'(tap);
  assign start_ok    = TRAIN_START &&
                       (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);

  // Next-state logic for the training sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: if (TRAIN_START) state_nx = ST_LOAD;
      ST_LOAD:    state_nx = ST_SETTLE;
      ST_SETTLE:  if (last_set) state_nx = ST_CHECK;
      ST_CHECK: begin
        if (last_chk) begin
          if (!k_ok && edge0)          state_nx = ST_CENTER;
          else if (tap_max || oor_now) state_nx = (edge0 || k_ok) ? ST_CENTER : ST_FAIL;
          else                         state_nx = ST_STEP;
        end
      end
      ST_STEP:    state_nx = ST_SETTLE;
      ST_CENTER:  if (!phase && at_center) state_nx = ST_FSETTLE;
      ST_FSETTLE: if (last_set) state_nx = ST_FCHECK;
      ST_FCHECK:  if (last_chk) state_nx = k_ok ? ST_DONE : ST_FAIL;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Sequencer state, tap tracking, window capture and rotation result.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tap        <= '0;
      edge0      <= 1'b0;
      oor_seen   <= 1'b0;
      chk_ok     <= 1'b0;
      chk_k      <= '0;
      phase      <= 1'b0;
      win_start  <= '0;
      win_end    <= '0;
      tap_center <= '0;
      slip       <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= (state_nx != state) ? '0 : cnt + 1'b1;
      oor_seen <= (state == ST_LOAD || state == ST_STEP) ? 1'b0 : oor_now;
      phase    <= (state == ST_CENTER) ? (!phase && !at_center) : 1'b0;
      if (state == ST_CHECK || state == ST_FCHECK) begin
        chk_ok <= k_ok;
        if (first) chk_k <= match_k;
      end
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (TRAIN_START) begin
            tap   <= '0;
            edge0 <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (last_chk && k_ok) begin
            if (!edge0) begin
              win_start <= tap8;
              edge0     <= 1'b1;
            end
            win_end <= tap8;
          end
        end
        ST_STEP:   tap <= tap + 1'b1;
        ST_CENTER: begin
          tap_center <= center_calc;
          if (!phase && !at_center) tap <= tap - 1'b1;
        end
        ST_FCHECK: if (last_chk && k_ok) slip <= match_k;
        default: ;
      endcase
    end
  end

  // Aligned data stage: one register after the rotator, same latency for any slip.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) data_out_p1 <= '0;
    else         data_out_p1 <= word_sel;
  end

`ifdef LPDDR3_RX_ALIGN_ERRCNT_EN
  logic [15:0] err_cnt;

  // Saturating count of aligned words that differ from the pattern after training.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N)                   err_cnt <= '0;
    else if (start_ok)             err_cnt <= '0;
    else if (state == ST_DONE && MON_EN && word_sel != TRAIN_PATTERN &&
             err_cnt != 16'hFFFF)  err_cnt <= err_cnt + 16'd1;
  end

  assign ERR_CNT = err_cnt;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

  assign DELAY_LINE_LOAD      = (state == ST_LOAD);
  assign DELAY_LINE_MOVE      = (state == ST_STEP) ||
                                (state == ST_CENTER && !phase && !at_center);
  assign DELAY_LINE_DIRECTION = (state == ST_STEP);
  assign RX_DATA_OUT          = data_out_p1;
  assign RX_VALID             = (state == ST_DONE);
  assign TRAIN_DONE           = (state == ST_DONE);
  assign TRAIN_FAIL           = (state == ST_FAIL);
  assign WIN_START            = win_start;
  assign WIN_END              = win_end;
  assign TAP_CENTER           = tap_center;
  assign SLIP                 = slip;

endmodule
